// File: rtl/regfile_scoreboard_if.sv
// Decode-stage register file bus: operand read ports, issue strobe,
// write-back port, flush and the registered pending-bit vector.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     wb_en;
  logic [ADDR_W-1:0]        wb_addr;
  logic [DATA_W-1:0]        wb_data;
  logic                     flush;
  logic [(1<<ADDR_W)-1:0]   busy_vec;

  // Pipeline side: drives addresses, issue, write-back and flush.
  modport master (
    output rd_addr, iss_valid, iss_addr, wb_en, wb_addr, wb_data, flush,
    input  rd_data, rd_busy, busy_vec
  );

  // Register file side.
  modport slave (
    input  rd_addr, iss_valid, iss_addr, wb_en, wb_addr, wb_data, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// General-purpose register file with NUM_RD combinational read ports, one
// write-back port, optional write-through bypass and a per-register
// pending-write scoreboard used by decode hazard logic.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic                 clk,
  input logic                 rst,
  regfile_scoreboard_if.slave bus
);

  localparam int DEPTH     = 1 << ADDR_W;
  localparam bit ZERO_EN   = (ZERO_REG != 0);
  localparam bit BYPASS_EN = (BYPASS != 0);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         busy;
  logic [DEPTH-1:0]         busy_nxt;
  logic                     wr_ok;
  logic                     iss_ok;
  logic [NUM_RD*DATA_W-1:0] rd_data_c;
  logic [NUM_RD-1:0]        rd_busy_c;

  // Writes and issues to the hard-wired zero register are dropped.
  assign wr_ok  = bus.wb_en && !(ZERO_EN && bus.wb_addr == '0);
  assign iss_ok = bus.iss_valid && !(ZERO_EN && bus.iss_addr == '0);

  // Register array: write-back port, cleared on reset.
  // NOTE: the array is reset on purpose -- a mid-run reset must leave no
  // stale operand behind; this costs a clear per flop instead of a RAM macro.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      mem[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard next state: flush, then issue (younger producer), then write-back.
  // NOTE: busy_nxt gets its full default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      if (bus.wb_en) busy_nxt[bus.wb_addr] = 1'b0;
      if (iss_ok)    busy_nxt[bus.iss_addr] = 1'b1;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  // Per-port read path: zero register, then bypass, then array.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              zero;

    assign addr = bus.rd_addr[k*ADDR_W +: ADDR_W];
    assign hit  = BYPASS_EN && bus.wb_en && (bus.wb_addr == addr);
    assign zero = ZERO_EN && (addr == '0);

    assign rd_data_c[k*DATA_W +: DATA_W] = (!rst || zero) ? '0
                                         : hit ? bus.wb_data : mem[addr];
    assign rd_busy_c[k] = rst && !zero && busy[addr] && !hit;
  end

  assign bus.rd_data  = rd_data_c;
  assign bus.rd_busy  = rd_busy_c;
  assign bus.busy_vec = busy;

endmodule
